// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad code-entry sequencer.
// Edge-detects debounced buttons, forwards one digit strobe per press to the
// code-entry block, evaluates its match flag after SIZE digits, and then grants
// a timed unlock or counts consecutive failures toward a timed lockout.
// Optional build macro: ENTRY_TIMEOUT_EN aborts a stalled entry after
// TIMEOUT_CYC idle cycles. When it is undefined, ENTRY waits indefinitely.
module lock_sequencer #(
  parameter int SIZE        = 6,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 1000,
  parameter int UNLOCK_CYC  = 5000,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] btns,
  input  logic       correct,
  output logic [8:0] key_evt,
  output logic       entry_clr,
  output logic       unlocked,
  output logic       lockout,
  output logic [1:0] fail_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ENTRY    = 3'd1,
    CHECK    = 3'd2,
    UNLOCKED = 3'd3,
    LOCKOUT  = 3'd4
  } state_t;

  // One timer is shared by UNLOCKED, LOCKOUT and (optionally) ENTRY idle tracking.
  localparam int TMAX_A = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
  localparam int TMAX   = (TMAX_A > TIMEOUT_CYC) ? TMAX_A : TIMEOUT_CYC;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int CW     = $clog2(SIZE + 1);
  localparam int FW     = $clog2(MAX_TRIES + 1);

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [TW-1:0]   timer_q, timer_n;
  logic [FW-1:0]   fail_q, fail_n;
  logic [8:0]      btns_q;
  logic [8:0]      key_q, key_n;
  logic            clr_q, clr_n;

  logic [8:0]      rise;
  logic [5:0]      digit_oh;
  logic            dig_any;
  logic            abort;
  logic            unused_rise;

  // Rising edges only. A held button yields a single event.
  assign rise        = btns & ~btns_q;
  // Isolate the lowest set digit rise so that simultaneous digits resolve to the lowest index.
  assign digit_oh    = rise[5:0] & (~rise[5:0] + 6'd1);
  assign dig_any     = |rise[5:0];
  assign abort       = rise[7] | rise[6];
  assign unused_rise = rise[8];

  // State, counters and registered output pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      fail_q  <= '0;
      btns_q  <= '0;
      key_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      timer_q <= timer_n;
      fail_q  <= fail_n;
      btns_q  <= btns;
      key_q   <= key_n;
      clr_q   <= clr_n;
    end
  end

  // Next-state logic. Within a state, lock/clear take priority over digits.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    timer_n = timer_q;
    fail_n  = fail_q;
    key_n   = '0;
    clr_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (abort) begin
          clr_n = 1'b1;
        end else if (dig_any) begin
          key_n[5:0] = digit_oh;
          cnt_n      = CW'(1);
          timer_n    = '0;
          state_n    = (SIZE == 1) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (abort) begin
          clr_n   = 1'b1;
          cnt_n   = '0;
          timer_n = '0;
          state_n = IDLE;
        end else if (dig_any) begin
          key_n[5:0] = digit_oh;
          cnt_n      = cnt_q + CW'(1);
          timer_n    = '0;
          if (cnt_q + CW'(1) == CW'(SIZE)) state_n = CHECK;
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          clr_n   = 1'b1;
          cnt_n   = '0;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer_q + TW'(1);
        end
`endif
      end
      CHECK: begin
        // The code register has absorbed the last digit by now, so correct is valid.
        clr_n   = 1'b1;
        cnt_n   = '0;
        timer_n = '0;
        if (correct) begin
          fail_n  = '0;
          state_n = UNLOCKED;
        end else begin
          fail_n  = fail_q + FW'(1);
          state_n = (fail_q + FW'(1) == FW'(MAX_TRIES)) ? LOCKOUT : IDLE;
        end
      end
      UNLOCKED: begin
        if (rise[7] || timer_q == TW'(UNLOCK_CYC - 1)) begin
          clr_n   = 1'b1;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end
      LOCKOUT: begin
        if (timer_q == TW'(LOCKOUT_CYC - 1)) begin
          fail_n  = '0;
          timer_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer_q + TW'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign key_evt   = key_q;
  assign entry_clr = clr_q;
  assign unlocked  = (state_q == UNLOCKED);
  assign lockout   = (state_q == LOCKOUT);
  assign fail_cnt  = 2'(fail_q);
  assign state     = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed scenarios plus randomized button traffic,
// checked every cycle against a behavioural model of the lock sequencer.
module tb_lock_sequencer;
  localparam int SIZE = 6, MAX_TRIES = 3, LOCKOUT_CYC = 8, UNLOCK_CYC = 16, TIMEOUT_CYC = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] btns = '0;
  logic       correct = 1'b0;
  logic [8:0] key_evt;
  logic       entry_clr, unlocked, lockout;
  logic [1:0] fail_cnt;
  logic [2:0] state;

  lock_sequencer #(.SIZE(SIZE), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYC(LOCKOUT_CYC),
                   .UNLOCK_CYC(UNLOCK_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .btns(btns), .correct(correct), .key_evt(key_evt),
    .entry_clr(entry_clr), .unlocked(unlocked), .lockout(lockout),
    .fail_cnt(fail_cnt), .state(state));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Behavioural model: the phase is named by the debug code it reports, the entered
  // code is kept as a queue, and timed phases count down the cycles that remain.
  localparam int P_IDLE = 0, P_ENTRY = 1, P_CHECK = 2, P_OPEN = 3, P_LOCKED = 4;
  int         m_phase = P_IDLE, m_fails = 0, m_remain = 0, m_idle = 0;
  int         m_code[$];
  logic [8:0] m_prev = '0, m_key = '0;
  bit         m_clr = 1'b0;

  initial forever begin
    logic [8:0] r;
    int dig;
    bit ab;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_IDLE; m_fails = 0; m_remain = 0; m_idle = 0;
      m_code.delete(); m_prev = '0; m_key = '0; m_clr = 1'b0;
    end else begin
      r = btns & ~m_prev;
      m_prev = btns;
      dig = -1;
      for (int i = 5; i >= 0; i--) if (r[i]) dig = i;
      ab = r[6] | r[7];
      m_key = '0;
      m_clr = 1'b0;
      case (m_phase)
        P_IDLE:
          if (ab) m_clr = 1'b1;
          else if (dig >= 0) begin
            m_key = 9'(1) << dig;
            m_code.delete(); m_code.push_back(dig);
            m_idle = 0;
            m_phase = (m_code.size() == SIZE) ? P_CHECK : P_ENTRY;
          end
        P_ENTRY:
          if (ab) begin
            m_clr = 1'b1; m_code.delete(); m_phase = P_IDLE;
          end else if (dig >= 0) begin
            m_key = 9'(1) << dig;
            m_code.push_back(dig);
            m_idle = 0;
            if (m_code.size() == SIZE) m_phase = P_CHECK;
          end else begin
`ifdef ENTRY_TIMEOUT_EN
            m_idle++;
            if (m_idle == TIMEOUT_CYC) begin
              m_clr = 1'b1; m_code.delete(); m_phase = P_IDLE;
            end
`endif
          end
        P_CHECK: begin
          m_clr = 1'b1;
          m_code.delete();
          if (correct) begin
            m_fails = 0; m_phase = P_OPEN; m_remain = UNLOCK_CYC;
          end else begin
            m_fails++;
            if (m_fails >= MAX_TRIES) begin
              m_phase = P_LOCKED; m_remain = LOCKOUT_CYC;
            end else m_phase = P_IDLE;
          end
        end
        P_OPEN: begin
          m_remain--;
          if (r[7] || m_remain == 0) begin
            m_clr = 1'b1; m_phase = P_IDLE;
          end
        end
        P_LOCKED: begin
          m_remain--;
          if (m_remain == 0) begin
            m_fails = 0; m_phase = P_IDLE;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  function automatic int dut_vec();
    return int'({key_evt, entry_clr, unlocked, lockout, fail_cnt, state});
  endfunction

  function automatic int model_vec();
    logic [1:0] f;
    logic [2:0] s;
    f = 2'(m_fails);
    s = 3'(m_phase);
    return int'({m_key, m_clr, m_phase == P_OPEN, m_phase == P_LOCKED, f, s});
  endfunction

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (run_cmp) chk("cycle_outputs", dut_vec(), model_vec());
  end

  // Press and release one digit; called and returning just after a falling edge.
  task automatic press(input int d);
    btns = 9'(1) << d;
    @(negedge clk);
    chk("press_key_evt", int'(key_evt), 1 << d);
    btns = '0;
    @(negedge clk);
  endtask

  initial begin
    int n, first, k;
    repeat (3) @(negedge clk);
    chk("reset_outputs", dut_vec(), 0);
    rst_n = 1'b1;
    run_cmp = 1'b1;
    @(negedge clk);

    // Correct code: six strobes, one CHECK cycle, then a 16-cycle unlock.
    correct = 1'b1;
    for (int d = 0; d < 5; d++) press(d);
    btns = 9'h020;
    @(negedge clk);
    chk("sixth_key_evt", int'(key_evt), 'h20);
    chk("check_state", int'(state), 2);
    btns = '0;
    @(negedge clk);
    chk("unlock_state", int'(state), 3);
    chk("unlock_clr", int'(entry_clr), 1);
    chk("unlock_flag", int'(unlocked), 1);
    n = 1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!unlocked) break;
      n++;
    end
    chk("unlock_cycles", n, 16);
    chk("relock_state", int'(state), 0);

    // Three wrong codes drive fail_cnt 1,2,3 and an 8-cycle lockout.
    correct = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      for (int d = 0; d < 6; d++) press(d);
      chk("fail_cnt_step", int'(fail_cnt), t);
      chk("after_fail_state", int'(state), (t < 3) ? 0 : 4);
    end
    chk("lockout_flag", int'(lockout), 1);
    n = 1;
    for (k = 0; k < 20; k++) begin
      btns = (k < 4 && k % 2 == 0) ? (9'(1) << k) : 9'h000;
      @(negedge clk);
      chk("lockout_no_key", int'(key_evt), 0);
      if (!lockout) break;
      n++;
    end
    btns = '0;
    chk("lockout_cycles", n, 8);
    chk("lockout_exit_fail", int'(fail_cnt), 0);
    chk("lockout_exit_state", int'(state), 0);
    @(negedge clk);

    // A held button produces exactly one strobe, one cycle after its rise.
    btns = 9'h001;
    n = 0; first = -1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (key_evt[0]) begin
        n++;
        if (first < 0) first = k;
      end
    end
    chk("held_pulses", n, 1);
    chk("held_latency", first, 0);
    btns = '0;
    @(negedge clk);

    // Simultaneous digit and clear: the clear wins.
    btns = 9'h044;
    @(negedge clk);
    chk("clr_priority_clr", int'(entry_clr), 1);
    chk("clr_priority_key", int'(key_evt), 0);
    chk("clr_priority_state", int'(state), 0);
    btns = '0;
    @(negedge clk);

`ifdef ENTRY_TIMEOUT_EN
    // Two digits, then the idle timeout aborts the entry.
    press(0);
    press(1);
    for (k = 2; k <= 20; k++) begin
      @(negedge clk);
      if (entry_clr) break;
    end
    chk("timeout_cycles", k, 10);
    chk("timeout_state", int'(state), 0);
    chk("timeout_fail", int'(fail_cnt), 0);
    @(negedge clk);
`endif

    // Reset mid-entry clears everything at once, and the next entry counts from 1.
    for (int d = 0; d < 3; d++) press(d);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", dut_vec(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 5; d++) press(d);
    chk("post_reset_still_entry", int'(state), 1);
    press(5);
    chk("post_reset_fail", int'(fail_cnt), 1);
    chk("post_reset_state", int'(state), 0);

    // Randomized traffic, checked by the model on every cycle.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 30) btns = '0;
      else if (r < 40) btns = btns;
      else if (r < 80) btns = 9'(1) << $urandom_range(0, 5);
      else if (r < 86) btns = 9'h040;
      else if (r < 91) btns = 9'h080;
      else btns = 9'($urandom);
      correct = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    btns = '0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
